// File: rtl/rvm_pcu_ctrl_if.sv
// Fetch-port bundle between the PC unit and instruction fetch.
// The master side presents the address; the slave side accepts it with fetch_ready.
interface rvm_pcu_ctrl_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;

  modport master (output fetch_valid, output pc, input fetch_ready);
  modport slave  (input fetch_valid, input pc, output fetch_ready);
endinterface

// File: rtl/rvm_pcu_ctrl.sv
// Program counter unit: fetch handshake, prioritised next-PC selection
// (trap > mret > redirect > sequential), trap vector and exception PC registers.
module rvm_pcu_ctrl #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter logic [XLEN-1:0] TVEC_RESET = XLEN'(32'h0000_0100),
  parameter int unsigned     IALIGN     = 4,
  parameter int unsigned     CAUSE_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  rvm_pcu_ctrl_if.master      fetch,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  input  logic                trap_valid,
  input  logic                trap_irq,
  input  logic [CAUSE_W-1:0]  trap_cause,
  input  logic [XLEN-1:0]     trap_pc,
  input  logic                mret_valid,
  input  logic                halt_req,
  output logic                halted,
  input  logic                tvec_w_en,
  input  logic                epc_w_en,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     tvec,
  output logic [XLEN-1:0]     epc,
  output logic                misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tvec_q, tvec_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic            fetch_valid_q, halted_q;

  logic [XLEN-1:0] trap_base, trap_target;
  logic            take_mret, take_redirect, redirect_bad, redirect_ok, flow_event;

  // Vectored mode (tvec[0]) only applies to interrupts; the sum wraps naturally.
  always_comb begin
    trap_base   = {tvec_q[XLEN-1:2], 2'b00};
    trap_target = trap_base;
    if (tvec_q[0] && trap_irq) begin
      trap_target = trap_base + (XLEN'(trap_cause) << 2);
    end
  end

  always_comb begin
    take_mret     = !trap_valid && mret_valid;
    take_redirect = !trap_valid && !mret_valid && redirect_valid;
    redirect_bad  = take_redirect && ((redirect_target & ALIGN_MASK) != '0);
    redirect_ok   = take_redirect && !redirect_bad;
    flow_event    = trap_valid || take_mret || redirect_ok;

    pc_d         = pc_q;
    tvec_d       = tvec_q;
    epc_d        = epc_q;
    misaligned_d = redirect_bad;
    state_d      = state_q;

    if (trap_valid) begin
      pc_d = trap_target;
    end else if (take_mret) begin
      pc_d = epc_q;
    end else if (redirect_ok) begin
      pc_d = redirect_target;
    end else if (!take_redirect && state_q == ST_FETCH && fetch.fetch_ready) begin
      pc_d = pc_q + XLEN'(4);
    end

    if (trap_valid) begin
      epc_d = trap_pc & ~ALIGN_MASK;
    end else if (epc_w_en) begin
      epc_d = csr_wdata & ~ALIGN_MASK;
    end

    if (tvec_w_en) begin
      tvec_d = csr_wdata & ~XLEN'(2);
    end

    // Halting needs a completed handshake so a pending request is never dropped.
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (!trap_valid && !mret_valid && !redirect_valid && halt_req && fetch.fetch_ready) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (flow_event) begin
          state_d = ST_FETCH;
        end else if (!redirect_bad && !halt_req) begin
          state_d = ST_FETCH;
        end
      end
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= PC_RESET;
      tvec_q        <= TVEC_RESET;
      epc_q         <= '0;
      misaligned_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tvec_q        <= tvec_d;
      epc_q         <= epc_d;
      misaligned_q  <= misaligned_d;
      fetch_valid_q <= (state_d == ST_FETCH);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign fetch.fetch_valid = fetch_valid_q;
  assign fetch.pc          = pc_q;
  assign halted            = halted_q;
  assign tvec              = tvec_q;
  assign epc               = epc_q;
  assign misaligned        = misaligned_q;

endmodule
